// File: rtl/aux_uart.sv
// aux_uart: 8N1 UART exposed as a 4-byte register window on the aux bus.
// TX and RX share one programmable bit-time prescaler; irq_o follows rx_valid.
`timescale 1ns/1ps
module aux_uart #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter logic [15:0] PRESCALE_RST = 16'd103
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] aux_adr_i,
    input  logic [7:0]  aux_dat_i,
    output logic [7:0]  aux_dat_o,
    output logic        aux_dat_oe_o,
    input  logic        aux_we_i,
    input  logic        aux_re_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic [15:0] uart_prescale_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    state_e      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_hold_q, tx_hold_d, tx_shift_q, tx_shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic        tx_ready_q, tx_ready_d, uart_tx_q, uart_tx_d;
    logic [1:0]  rx_sync_q, rx_sync_d;
    logic        rx_prev_q, rx_prev_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        rx_frame_q, rx_frame_d;

    logic [15:0] adr_off;
    logic        in_win, wr_data, wr_status, wr_pre_lo, wr_pre_hi, rd_data;
    logic [15:0] bit_reload, half_reload;
    logic        rx_line, rx_done, rx_bad, tx_load;
    logic [7:0]  status, rd_mux;

    assign rx_line         = rx_sync_q[1];
    assign uart_tx_o       = uart_tx_q;
    assign uart_prescale_o = prescale_q;
    assign irq_o           = rx_valid_q;
    assign aux_dat_oe_o    = aux_re_i && in_win;
    assign aux_dat_o       = aux_dat_oe_o ? rd_mux : 8'h00;

    always_comb begin
        adr_off   = aux_adr_i - BASE_ADDR;
        in_win    = (adr_off[15:2] == 14'd0);
        wr_data   = aux_we_i && in_win && (adr_off[1:0] == 2'd0);
        wr_status = aux_we_i && in_win && (adr_off[1:0] == 2'd1);
        wr_pre_lo = aux_we_i && in_win && (adr_off[1:0] == 2'd2);
        wr_pre_hi = aux_we_i && in_win && (adr_off[1:0] == 2'd3);
        rd_data   = aux_re_i && in_win && (adr_off[1:0] == 2'd0);
        // Bit time is reload+1 clocks; the RX start check waits floor(bit/2) clocks.
        bit_reload  = (prescale_q < 16'd3) ? 16'd3 : prescale_q;
        half_reload = (bit_reload >> 1) + {15'd0, bit_reload[0]} - 16'd1;
        status = {3'b000, (tx_state_q != ST_IDLE), rx_frame_q, rx_overrun_q,
                  rx_valid_q, tx_ready_q};
        case (adr_off[1:0])
            2'd0:    rd_mux = rx_data_q;
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = prescale_q[7:0];
            default: rd_mux = prescale_q[15:8];
        endcase
        prescale_d = prescale_q;
        if (wr_pre_lo) prescale_d[7:0]  = aux_dat_i;
        if (wr_pre_hi) prescale_d[15:8] = aux_dat_i;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_ready_d = tx_ready_q;
        uart_tx_d  = uart_tx_q;
        tx_load    = 1'b0;
        if (wr_data && tx_ready_q) begin
            tx_hold_d  = aux_dat_i;
            tx_ready_d = 1'b0;
        end
        case (tx_state_q)
            ST_IDLE: begin
                uart_tx_d = 1'b1;
                tx_load   = !tx_ready_q;
            end
            ST_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = bit_reload;
                    tx_bit_d   = 3'd0;
                    uart_tx_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = bit_reload;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        uart_tx_d  = 1'b1;
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        uart_tx_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = ST_IDLE;
                    tx_load    = !tx_ready_q;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase
        // A full holding register starts the next frame with no idle gap.
        if (tx_load) begin
            tx_state_d = ST_START;
            tx_cnt_d   = bit_reload;
            tx_shift_d = tx_hold_q;
            tx_ready_d = 1'b1;
            uart_tx_d  = 1'b0;
        end
    end

    always_comb begin
        rx_sync_d  = {rx_sync_q[0], uart_rx_i};
        rx_prev_d  = rx_line;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_line) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = half_reload;
                end
            end
            ST_START: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = rx_line ? ST_IDLE : ST_DATA;
                    rx_cnt_d   = bit_reload;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_cnt_d   = bit_reload;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = ST_IDLE;
                    rx_done    = rx_line;
                    rx_bad     = !rx_line;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase
        // A DATA read on the completing edge frees the slot for the new byte.
        rx_valid_d   = rx_valid_q && !rd_data;
        rx_overrun_d = rx_overrun_q && !(wr_status && aux_dat_i[2]);
        rx_frame_d   = rx_frame_q && !(wr_status && aux_dat_i[3]);
        if (rx_done) begin
            if (rx_valid_d) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end
        if (rx_bad) rx_frame_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prescale_q   <= PRESCALE_RST;
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= 16'd0;
            tx_bit_q     <= 3'd0;
            tx_ready_q   <= 1'b1;
            uart_tx_q    <= 1'b1;
            rx_sync_q    <= 2'b11;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= 16'd0;
            rx_bit_q     <= 3'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_frame_q   <= 1'b0;
        end else begin
            prescale_q   <= prescale_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_ready_q   <= tx_ready_d;
            uart_tx_q    <= uart_tx_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            rx_frame_q   <= rx_frame_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by control state.
    always_ff @(posedge clk_i) begin
        tx_hold_q  <= tx_hold_d;
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
        rx_data_q  <= rx_data_d;
    end
endmodule
